// File: rtl/q_episode_ctrl.sv
// Top-level sequencer for the Q-learning maze datapath: trains for NUM_EPISODES
// episodes, then walks the learned greedy path once, with move watchdog and fault latching.
module q_episode_ctrl #(
    parameter int unsigned NUM_EPISODES = 200,
    parameter int unsigned MAX_STEPS    = 64,
    parameter int unsigned MOVE_TIMEOUT = 50000000,
    parameter int unsigned NUM_STATES   = 37
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        abort,
    input  logic [5:0]  start_state,
    input  logic [5:0]  target_state,
    input  logic [5:0]  maze_state,
    input  logic        move_complete,
    output logic        explore_en,
    output logic        exploit_en,
    output logic        episode_reset,
    output logic        timer_start,
    output logic [15:0] episode_count,
    output logic [7:0]  step_count,
    output logic        run_done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [3:0]  state_dbg
);

    // Move handshake: timer_start is a one-cycle request issued on entry to a MOVE
    // state; move_complete is a one-cycle response that is honoured only while in a
    // MOVE state, with maze_state sampled in that same cycle.
    typedef enum logic [3:0] {
        ST_IDLE, ST_EP_INIT, ST_EX_MOVE, ST_EX_CHECK,
        ST_XP_INIT, ST_XP_MOVE, ST_XP_CHECK, ST_FINISHED, ST_FAULT
    } state_t;

    localparam logic [15:0] EP_LAST    = 16'(NUM_EPISODES);
    localparam logic [7:0]  STEP_MAX   = 8'(MAX_STEPS);
    localparam logic [25:0] WD_LAST    = 26'(MOVE_TIMEOUT - 1);
    localparam logic [6:0]  STATE_LIM  = 7'(NUM_STATES);
    localparam logic [1:0]  FC_TIMEOUT = 2'b01;
    localparam logic [1:0]  FC_XP_LIM  = 2'b10;
    localparam logic [1:0]  FC_CONFIG  = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] episode_count_q, episode_count_d;
    logic [7:0]  step_count_q, step_count_d;
    logic [25:0] watchdog_q, watchdog_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        hit_q, hit_d;
    logic        cfg_bad;
    logic        in_move;
    logic        step_limit;

    assign cfg_bad    = (start_state == target_state)
                     || ({1'b0, start_state} >= STATE_LIM)
                     || ({1'b0, target_state} >= STATE_LIM);
    assign in_move    = (state_q == ST_EX_MOVE) || (state_q == ST_XP_MOVE);
    assign step_limit = (step_count_q >= STEP_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            episode_count_q <= '0;
            step_count_q    <= '0;
            watchdog_q      <= '0;
            fault_code_q    <= '0;
            hit_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            episode_count_q <= episode_count_d;
            step_count_q    <= step_count_d;
            watchdog_q      <= watchdog_d;
            fault_code_q    <= fault_code_d;
            hit_q           <= hit_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        episode_count_d = episode_count_q;
        step_count_d    = step_count_q;
        watchdog_d      = watchdog_q;
        fault_code_d    = fault_code_q;
        hit_d           = hit_q;

        if (abort) begin
            state_d         = ST_IDLE;
            episode_count_d = '0;
            step_count_d    = '0;
            watchdog_d      = '0;
            fault_code_d    = '0;
            hit_d           = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FINISHED, ST_FAULT: begin
                    if (go) begin
                        episode_count_d = '0;
                        step_count_d    = '0;
                        watchdog_d      = '0;
                        hit_d           = 1'b0;
                        if (cfg_bad) begin
                            state_d      = ST_FAULT;
                            fault_code_d = FC_CONFIG;
                        end else begin
                            state_d      = ST_EP_INIT;
                            fault_code_d = '0;
                        end
                    end
                end
                ST_EP_INIT: begin
                    step_count_d = '0;
                    watchdog_d   = '0;
                    state_d      = ST_EX_MOVE;
                end
                ST_XP_INIT: begin
                    step_count_d = '0;
                    watchdog_d   = '0;
                    state_d      = ST_XP_MOVE;
                end
                ST_EX_MOVE, ST_XP_MOVE: begin
                    // A completion arriving on the last watchdog cycle still counts.
                    if (move_complete) begin
                        if (step_count_q < STEP_MAX) begin
                            step_count_d = step_count_q + 8'd1;
                        end
                        hit_d   = (maze_state == target_state);
                        state_d = (state_q == ST_EX_MOVE) ? ST_EX_CHECK : ST_XP_CHECK;
                    end else if (watchdog_q >= WD_LAST) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_TIMEOUT;
                    end else begin
                        watchdog_d = watchdog_q + 26'd1;
                    end
                end
                ST_EX_CHECK: begin
                    watchdog_d = '0;
                    if (hit_q || step_limit) begin
                        if (episode_count_q < EP_LAST) begin
                            episode_count_d = episode_count_q + 16'd1;
                        end
                        state_d = (episode_count_d >= EP_LAST) ? ST_XP_INIT : ST_EP_INIT;
                    end else begin
                        state_d = ST_EX_MOVE;
                    end
                end
                ST_XP_CHECK: begin
                    watchdog_d = '0;
                    if (hit_q) begin
                        state_d = ST_FINISHED;
                    end else if (step_limit) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_XP_LIM;
                    end else begin
                        state_d = ST_XP_MOVE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign explore_en    = (state_q == ST_EX_MOVE);
    assign exploit_en    = (state_q == ST_XP_MOVE);
    assign episode_reset = (state_q == ST_EP_INIT) || (state_q == ST_XP_INIT);
    assign timer_start   = in_move && (watchdog_q == '0);
    assign episode_count = episode_count_q;
    assign step_count    = step_count_q;
    assign run_done      = (state_q == ST_FINISHED);
    assign fault         = (state_q == ST_FAULT);
    assign fault_code    = fault_code_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_q_episode_ctrl.sv
// Directed-plus-random bench for q_episode_ctrl; episode outcomes are predicted from
// the episode/exploit termination rules applied to the generated move sequence.
module tb_q_episode_ctrl;

    localparam int NUM_EP = 2;
    localparam int MAX_ST = 4;
    localparam int TO     = 16;
    localparam int NS     = 37;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        abort;
    logic [5:0]  start_state;
    logic [5:0]  target_state;
    logic [5:0]  maze_state;
    logic        move_complete;
    logic        explore_en;
    logic        exploit_en;
    logic        episode_reset;
    logic        timer_start;
    logic [15:0] episode_count;
    logic [7:0]  step_count;
    logic        run_done;
    logic        fault;
    logic [1:0]  fault_code;
    logic [3:0]  state_dbg;
    logic [3:0]  idle_code;

    int n_vec = 0;
    int n_bad = 0;

    q_episode_ctrl #(
        .NUM_EPISODES(NUM_EP),
        .MAX_STEPS   (MAX_ST),
        .MOVE_TIMEOUT(TO),
        .NUM_STATES  (NS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .abort        (abort),
        .start_state  (start_state),
        .target_state (target_state),
        .maze_state   (maze_state),
        .move_complete(move_complete),
        .explore_en   (explore_en),
        .exploit_en   (exploit_en),
        .episode_reset(episode_reset),
        .timer_start  (timer_start),
        .episode_count(episode_count),
        .step_count   (step_count),
        .run_done     (run_done),
        .fault        (fault),
        .fault_code   (fault_code),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Output invariants checked every cycle while out of reset.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("excl_explore_exploit", 32'(explore_en & exploit_en), 0);
            chk("excl_reset_timer", 32'(episode_reset & timer_start), 0);
            chk("step_le_max", 32'(step_count <= 8'(MAX_ST)), 1);
            chk("episode_le_num", 32'(episode_count <= 16'(NUM_EP)), 1);
        end
    end

    function automatic logic [5:0] other_state(input logic [5:0] t);
        int v;
        v = (int'(t) + 1 + int'($urandom_range(0, NS - 2))) % NS;
        return 6'(v);
    endfunction

    function automatic bit pick_hit(input int mode, input int step);
        case (mode)
            0:       return ($urandom_range(0, 99) < 35);
            1:       return (step == 2);
            default: return 1'b0;
        endcase
    endfunction

    task automatic start_run(input logic [5:0] s, input logic [5:0] t);
        start_state  = s;
        target_state = t;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic abort_pulse();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_timer(input bit exp_xp);
        int n = 0;
        while (timer_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("timer_start_seen", 32'(timer_start), 1);
        chk("explore_en_in_move", 32'(explore_en), 32'(!exp_xp));
        chk("exploit_en_in_move", 32'(exploit_en), 32'(exp_xp));
    endtask

    // Called on the timer_start cycle; answers dly cycles later and returns on the CHECK cycle.
    task automatic pulse_move(input logic [5:0] ms, input int dly);
        repeat (dly) tick();
        maze_state    = ms;
        move_complete = 1'b1;
        tick();
        move_complete = 1'b0;
    endtask

    task automatic run_full(input logic [5:0] s, input logic [5:0] t, input int mode,
                            input bit rdly, input bit stop_xp);
        int steps;
        bit hit;
        bit ended;
        int dly;
        hit = 1'b0;
        start_run(s, t);
        chk("ep_reset_after_go", 32'(episode_reset), 1);
        chk("no_timer_in_init", 32'(timer_start), 0);
        chk("episode_cleared", 32'(episode_count), 0);
        tick();
        chk("go_to_timer_2cyc", 32'(timer_start), 1);
        for (int e = 0; e < NUM_EP; e++) begin
            steps = 0;
            ended = 1'b0;
            while (!ended) begin
                wait_timer(1'b0);
                chk("train_step_at_move", 32'(step_count), 32'(steps));
                steps++;
                hit = pick_hit(mode, steps);
                dly = rdly ? int'($urandom_range(0, 4)) : 3;
                pulse_move(hit ? t : other_state(t), dly);
                chk("train_step_count", 32'(step_count), 32'(steps));
                ended = hit || (steps == MAX_ST);
            end
            tick();
            chk("train_episode_count", 32'(episode_count), 32'(e + 1));
            chk("episode_reset_pulse", 32'(episode_reset), 1);
            if (e == NUM_EP - 1) chk("explore_off_xp_init", 32'(explore_en), 0);
        end
        steps = 0;
        ended = 1'b0;
        while (!ended) begin
            wait_timer(1'b1);
            chk("xp_step_at_move", 32'(step_count), 32'(steps));
            if (stop_xp) return;
            steps++;
            hit = pick_hit(mode, steps);
            dly = rdly ? int'($urandom_range(0, 4)) : 3;
            pulse_move(hit ? t : other_state(t), dly);
            chk("xp_step_count", 32'(step_count), 32'(steps));
            ended = hit || (steps == MAX_ST);
        end
        tick();
        chk("run_done_result", 32'(run_done), 32'(hit));
        chk("fault_result", 32'(fault), 32'(!hit));
        chk("fault_code_result", 32'(fault_code), hit ? 0 : 2);
        chk("exploit_off_at_end", 32'(exploit_en), 0);
        chk("episode_hold_at_end", 32'(episode_count), NUM_EP);
        chk("step_hold_at_end", 32'(step_count), 32'(steps));
    endtask

    initial begin
        logic [5:0] s;
        rst = 1'b0; go = 1'b0; abort = 1'b0;
        start_state = '0; target_state = '0; maze_state = '0; move_complete = 1'b0;
        tick();
        idle_code = state_dbg;
        chk("rst_explore", 32'(explore_en), 0);
        chk("rst_exploit", 32'(exploit_en), 0);
        chk("rst_ep_reset", 32'(episode_reset), 0);
        chk("rst_timer", 32'(timer_start), 0);
        chk("rst_episode", 32'(episode_count), 0);
        chk("rst_step", 32'(step_count), 0);
        chk("rst_run_done", 32'(run_done), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_fault_code", 32'(fault_code), 0);
        tick();
        rst = 1'b1;
        tick();

        // stray move_complete in IDLE
        maze_state = 6'd5;
        move_complete = 1'b1;
        tick();
        move_complete = 1'b0;
        tick();
        chk("idle_stray_step", 32'(step_count), 0);
        chk("idle_stray_episode", 32'(episode_count), 0);
        chk("idle_stray_timer", 32'(timer_start), 0);
        chk("idle_stray_ep_reset", 32'(episode_reset), 0);

        // nominal run: target on the 2nd move of every run
        run_full(6'd0, 6'd5, 1, 1'b0, 1'b0);

        // stray move_complete in FINISHED, then restart
        maze_state = 6'd5;
        move_complete = 1'b1;
        tick();
        move_complete = 1'b0;
        chk("fin_stray_step", 32'(step_count), 2);
        chk("fin_stray_episode", 32'(episode_count), NUM_EP);
        chk("fin_stray_run_done", 32'(run_done), 1);
        start_run(6'd0, 6'd5);
        chk("restart_episode_zero", 32'(episode_count), 0);
        chk("restart_run_done_clr", 32'(run_done), 0);
        chk("restart_ep_reset", 32'(episode_reset), 1);
        abort_pulse();

        // step limit in training and exploit
        run_full(6'd1, 6'd9, 2, 1'b0, 1'b0);
        abort_pulse();

        // randomized runs
        for (int i = 0; i < 4; i++) begin
            s = 6'($urandom_range(0, NS - 1));
            run_full(s, other_state(s), 0, 1'b1, 1'b0);
        end
        abort_pulse();

        // move timeout
        start_run(6'd2, 6'd6);
        tick();
        chk("to_timer_start", 32'(timer_start), 1);
        repeat (TO - 1) tick();
        chk("to_no_fault_early", 32'(fault), 0);
        tick();
        chk("to_fault", 32'(fault), 1);
        chk("to_fault_code", 32'(fault_code), 1);
        chk("to_explore_off", 32'(explore_en), 0);
        // completion on the timeout cycle wins
        start_run(6'd2, 6'd6);
        chk("to_restart_fault_clr", 32'(fault), 0);
        tick();
        chk("to2_timer_start", 32'(timer_start), 1);
        pulse_move(6'd3, TO - 1);
        chk("to2_no_fault", 32'(fault), 0);
        chk("to2_step", 32'(step_count), 1);
        tick();
        chk("to2_next_move", 32'(timer_start), 1);
        abort_pulse();

        // bad configuration
        start_run(6'd7, 6'd7);
        chk("cfg_eq_fault", 32'(fault), 1);
        chk("cfg_eq_code", 32'(fault_code), 3);
        chk("cfg_eq_no_timer", 32'(timer_start), 0);
        tick();
        chk("cfg_eq_no_timer2", 32'(timer_start), 0);
        abort_pulse();
        chk("cfg_abort_clr", 32'(fault), 0);
        start_run(6'd3, 6'd40);
        chk("cfg_range_fault", 32'(fault), 1);
        chk("cfg_range_code", 32'(fault_code), 3);
        tick();
        chk("cfg_range_no_timer", 32'(timer_start), 0);
        abort_pulse();

        // abort mid-move in the second episode, with stray inputs first
        start_run(6'd0, 6'd5);
        tick();
        pulse_move(6'd5, 1);
        tick();
        chk("ab_episode_one", 32'(episode_count), 1);
        wait_timer(1'b0);
        pulse_move(6'd3, 2);
        maze_state = 6'd3;
        move_complete = 1'b1;
        tick();
        move_complete = 1'b0;
        chk("check_stray_step", 32'(step_count), 1);
        chk("check_stray_timer", 32'(timer_start), 1);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_in_move_step", 32'(step_count), 1);
        chk("go_in_move_episode", 32'(episode_count), 1);
        chk("go_in_move_ep_reset", 32'(episode_reset), 0);
        chk("go_in_move_explore", 32'(explore_en), 1);
        abort_pulse();
        chk("ab_explore", 32'(explore_en), 0);
        chk("ab_step", 32'(step_count), 0);
        chk("ab_episode", 32'(episode_count), 0);
        chk("ab_state_idle", 32'(state_dbg), 32'(idle_code));
        tick();
        chk("ab_no_autostart", 32'(episode_reset), 0);

        // asynchronous reset during exploit move
        run_full(6'd0, 6'd5, 1, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_exploit", 32'(exploit_en), 0);
        chk("arst_explore", 32'(explore_en), 0);
        chk("arst_timer", 32'(timer_start), 0);
        chk("arst_episode", 32'(episode_count), 0);
        chk("arst_step", 32'(step_count), 0);
        chk("arst_fault", 32'(fault), 0);
        chk("arst_run_done", 32'(run_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL global_timeout: observed running expected finished");
    end

endmodule

// File: doc/q_episode_ctrl.md
Name: q_episode_ctrl

Overview:
- Top-level sequencer for the Q-learning maze datapath.
- Runs NUM_EPISODES training episodes with the explore datapath enabled, then one exploit run that walks the learned greedy path from start_state to target_state.
- Issues the per-move handshake to the motor/timer side, counts steps and episodes, and flags faults for move timeout, exploit non-convergence and bad configuration.

Parameters:
- NUM_EPISODES, 200, number of training episodes before exploit; valid range 1..65535.
- MAX_STEPS, 64, step limit per episode or exploit run; valid range 1..255.
- MOVE_TIMEOUT, 50000000, clock cycles allowed between timer_start and move_complete.
- NUM_STATES, 37, number of valid maze states; valid states are 0..NUM_STATES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- go  in  1  single-cycle start request
- abort  in  1  synchronous abort to IDLE
- start_state  in  6  episode start cell
- target_state  in  6  goal cell
- maze_state  in  6  current robot cell, valid when move_complete is seen
- move_complete  in  1  single-cycle pulse when the robot finishes a move
- explore_en  out  1  explore datapath active
- exploit_en  out  1  exploit datapath active; this is the done input of the exploit path
- episode_reset  out  1  single-cycle pulse: datapath reloads start_state
- timer_start  out  1  single-cycle pulse: begin one move
- episode_count  out  16  completed training episodes
- step_count  out  8  moves in the current episode or run
- run_done  out  1  exploit reached target; held
- fault  out  1  fault latched; held
- fault_code  out  2  01 timeout, 10 exploit step limit, 11 bad config

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0.
- Priority: rst > abort > everything else. abort in any state forces IDLE next cycle and clears all counters, run_done and fault.
- IDLE: on go, check config. If start_state==target_state, or either is >= NUM_STATES, go to FAULT with fault_code=11. Otherwise go to EP_INIT.
- EP_INIT (1 cycle): episode_reset=1, step_count<=0, watchdog<=0. Next state EX_MOVE.
- EX_MOVE:
  - explore_en=1.
  - timer_start=1 on the entry cycle only; watchdog<=0 on entry, then increments every cycle.
  - On move_complete: step_count+1, go to EX_CHECK.
  - If watchdog reaches MOVE_TIMEOUT-1 without move_complete: FAULT, code 01.
  - move_complete and timeout in the same cycle: move_complete wins.
- EX_CHECK (1 cycle):
  - Episode ends if maze_state==target_state or step_count==MAX_STEPS. When it ends, episode_count+1.
  - After an episode ends: if the new count equals NUM_EPISODES, go to XP_INIT; otherwise go to EP_INIT.
  - If the episode has not ended: go to EX_MOVE.
- XP_INIT (1 cycle): episode_reset=1, explore_en=0, step_count<=0. Next state XP_MOVE.
- XP_MOVE: same as EX_MOVE, but with exploit_en=1 instead of explore_en.
- XP_CHECK:
  - maze_state==target_state: go to FINISHED.
  - Else if step_count==MAX_STEPS: FAULT, code 10.
  - Else: go to XP_MOVE.
  - Target match on the step that reaches MAX_STEPS counts as success.
- FINISHED: run_done=1 and exploit_en=0. episode_count and step_count hold their values.
- FAULT: fault=1 and fault_code are held; explore_en=0 and exploit_en=0.
- In FINISHED or FAULT, go restarts the IDLE config check on the next cycle. The restart clears the counters, run_done and fault.
- go is ignored in all other states.
- move_complete outside EX_MOVE/XP_MOVE is ignored. A stray pulse does not advance counters.
- Latency: go to first timer_start is 2 cycles (IDLE→EP_INIT→EX_MOVE). Each move is 1 cycle after move_complete for CHECK, plus 1 cycle to re-enter MOVE.
- Counters: episode_count is 16 bits and saturates at NUM_EPISODES; step_count is 8 bits and never exceeds MAX_STEPS; watchdog is 26 bits. No wrap-around is permitted.
- explore_en and exploit_en are never high together. episode_reset and timer_start are never high in the same cycle.

Test Plan:
- Config: NUM_EPISODES=2, MAX_STEPS=4, MOVE_TIMEOUT=16. Sequence: go with start=0, target=5; each timer_start answered after 3 cycles; maze_state=5 on the 2nd move of every run. Required: 2 episodes with step_count=2; episode_count=2; XP_INIT pulse; run_done=1 after the exploit run reaches target in 2 steps. fault=0 throughout.
- Episode step limit: maze_state never equals target during training. Each episode ends at step_count=4 and the episode counter advances. Exploit run never reaches target: fault=1, fault_code=10 after the 4th exploit move.
- Timeout: withhold move_complete after the first timer_start. fault=1, fault_code=01 exactly 16 cycles after the timer_start cycle. Then drive move_complete on the timeout cycle in a second run and require it to win (no fault).
- Bad config: go with start=target=7 gives FAULT, code 11, next cycle. go with target=40 gives code 11. No timer_start is issued in either case.
- Abort/reset: abort mid-EX_MOVE at episode 1, step 2. Next cycle: IDLE, all counters 0, explore_en=0. Assert rst low mid-XP_MOVE: all outputs 0 asynchronously.
- Stray/ignored inputs: move_complete pulses in IDLE, EX_CHECK and FINISHED leave the counters unchanged. go during EX_MOVE has no effect. go in FINISHED restarts with episode_count=0.
